// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// elaboration-time sizing helpers.
package divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int max_f(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int clog2_f(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Iteration counter width, never less than one bit
    function automatic int cnt_width(input int width_n);
        return max_f(clog2_f(width_n), 1);
    endfunction

endpackage

// File: rtl/divider_seq_if.sv
// Operand/result handshake bundle of the sequential divider.
interface divider_seq_if #(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 16
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_N-1:0] N;
    logic [WIDTH_D-1:0] D;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH_N-1:0] Q;
    logic [WIDTH_D-1:0] R;
    logic               div_by_zero;
    logic               busy;

    modport master (
        output in_valid, N, D, out_ready,
        input  in_ready, out_valid, Q, R, div_by_zero, busy
    );

    modport slave (
        input  in_valid, N, D, out_ready,
        output in_ready, out_valid, Q, R, div_by_zero, busy
    );
endinterface

// File: rtl/divider_step.sv
// One restoring-division cell: shift a dividend bit into the partial
// remainder, trial-subtract the divisor magnitude, restore on underflow.
module divider_step #(
    parameter int WIDTH_D = 16
) (
    input  logic [WIDTH_D:0]   rem_in,
    input  logic               bit_in,
    input  logic [WIDTH_D-1:0] dmag,
    output logic [WIDTH_D:0]   rem_out,
    output logic               q_bit
);
    logic [WIDTH_D+1:0] ext_s;
    logic [WIDTH_D:0]   diff_s;

    // Trial subtraction; the difference is only kept when it fits, so its width is enough
    always_comb begin
        ext_s  = {rem_in, bit_in};
        diff_s = ext_s[WIDTH_D:0] - {1'b0, dmag};
        q_bit  = (ext_s >= {2'b00, dmag});
        if (q_bit) begin
            rem_out = diff_s;
        end else begin
            rem_out = ext_s[WIDTH_D:0];
        end
    end
endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per cycle, optional
// two's-complement operation with truncating semantics.
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH_N = 16,
    parameter int WIDTH_D = 16,
    parameter int SIGNED  = 0
) (
    input  logic         clk,
    input  logic         rst,
    divider_seq_if.slave bus
);
    localparam int                 CW       = cnt_width(WIDTH_N);
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH_N - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [WIDTH_N-1:0] N_MIN    = {1'b1, {(WIDTH_N-1){1'b0}}};

    state_t             state;
    logic               in_ready_r, out_valid_r, busy_r, dbz_r, dbz_pend_r;
    logic               q_neg_r, r_neg_r;
    logic [WIDTH_N-1:0] q_r, dvd_r;
    logic [WIDTH_D-1:0] r_r, dmag_r;
    logic [WIDTH_D:0]   rem_r;
    logic [CW-1:0]      cnt_r;

    logic               n_neg_s, d_neg_s, ovf_s, step_q_s;
    logic [WIDTH_N-1:0] n_mag_s;
    logic [WIDTH_D-1:0] d_mag_s;
    logic [WIDTH_D:0]   step_rem_s;

    // Operand magnitudes and the single overflowing signed combination
    always_comb begin
        n_neg_s = (SIGNED != 0) && bus.N[WIDTH_N-1];
        d_neg_s = (SIGNED != 0) && bus.D[WIDTH_D-1];
        n_mag_s = n_neg_s ? (-bus.N) : bus.N;
        d_mag_s = d_neg_s ? (-bus.D) : bus.D;
        ovf_s   = (SIGNED != 0) && (bus.N == N_MIN) && (bus.D == '1);
    end

    divider_step #(.WIDTH_D(WIDTH_D)) u_step (
        .rem_in  (rem_r),
        .bit_in  (dvd_r[WIDTH_N-1]),
        .dmag    (dmag_r),
        .rem_out (step_rem_s),
        .q_bit   (step_q_s)
    );

    // Control FSM and datapath; dvd_r shifts the dividend out and the quotient in
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            q_r         <= '0;
            r_r         <= '0;
            dbz_r       <= 1'b0;
            dbz_pend_r  <= 1'b0;
            cnt_r       <= '0;
            dvd_r       <= '0;
            dmag_r      <= '0;
            rem_r       <= '0;
            q_neg_r     <= 1'b0;
            r_neg_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (bus.D == '0) begin
                            state      <= DONE;
                            dvd_r      <= '1;
                            rem_r      <= {1'b0, bus.N[WIDTH_D-1:0]};
                            q_neg_r    <= 1'b0;
                            r_neg_r    <= 1'b0;
                            dbz_pend_r <= 1'b1;
                        end else if (ovf_s) begin
                            state      <= DONE;
                            dvd_r      <= bus.N;
                            rem_r      <= '0;
                            q_neg_r    <= 1'b0;
                            r_neg_r    <= 1'b0;
                            dbz_pend_r <= 1'b0;
                        end else begin
                            state      <= CALC;
                            cnt_r      <= CNT_LAST;
                            dvd_r      <= n_mag_s;
                            dmag_r     <= d_mag_s;
                            rem_r      <= '0;
                            q_neg_r    <= n_neg_s ^ d_neg_s;
                            r_neg_r    <= n_neg_s;
                            dbz_pend_r <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_r <= step_rem_s;
                    dvd_r <= {dvd_r[WIDTH_N-2:0], step_q_s};
                    if (cnt_r == '0) begin
                        state <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the signed result; later cycles hold it
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        q_r         <= q_neg_r ? (-dvd_r) : dvd_r;
                        r_r         <= r_neg_r ? (-rem_r[WIDTH_D-1:0]) : rem_r[WIDTH_D-1:0];
                        dbz_r       <= dbz_pend_r;
                    end else if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.busy        = busy_r;
    assign bus.Q           = q_r;
    assign bus.R           = r_r;
    assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench: an unsigned and a signed 8-bit divider driven with directed
// and random operands, results checked against plain-arithmetic expectations.
module tb_divider_seq;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid [2];
    logic       out_ready [2];
    logic [7:0] n_in [2];
    logic [7:0] d_in [2];
    logic       ir [2];
    logic       ov [2];
    logic       busy_o [2];
    logic       dbz_o [2];
    logic [7:0] q_o [2];
    logic [7:0] r_o [2];

    exp_t sb0 [$];
    exp_t sb1 [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   tx [2];
    int   rx [2];
    bit   rand_done;

    always #5 clk = ~clk;

    divider_seq_if #(.WIDTH_N(8), .WIDTH_D(8)) if0 ();
    divider_seq_if #(.WIDTH_N(8), .WIDTH_D(8)) if1 ();

    divider_seq #(.WIDTH_N(8), .WIDTH_D(8), .SIGNED(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    divider_seq #(.WIDTH_N(8), .WIDTH_D(8), .SIGNED(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    assign if0.in_valid  = in_valid[0];
    assign if0.N         = n_in[0];
    assign if0.D         = d_in[0];
    assign if0.out_ready = out_ready[0];
    assign if1.in_valid  = in_valid[1];
    assign if1.N         = n_in[1];
    assign if1.D         = d_in[1];
    assign if1.out_ready = out_ready[1];

    assign ir[0] = if0.in_ready;    assign ir[1] = if1.in_ready;
    assign ov[0] = if0.out_valid;   assign ov[1] = if1.out_valid;
    assign busy_o[0] = if0.busy;    assign busy_o[1] = if1.busy;
    assign dbz_o[0] = if0.div_by_zero; assign dbz_o[1] = if1.div_by_zero;
    assign q_o[0] = if0.Q;          assign q_o[1] = if1.Q;
    assign r_o[0] = if0.R;          assign r_o[1] = if1.R;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Reference: C-style truncating division on the integer values
    function automatic exp_t model(input int i, input logic [7:0] n, input logic [7:0] d);
        exp_t e;
        int sn, sd;
        if (d == 8'd0) begin
            e.q = 8'hFF; e.r = n; e.dbz = 1'b1;
        end else if (i == 0) begin
            e.q = n / d; e.r = n % d; e.dbz = 1'b0;
        end else begin
            sn = int'($signed(n));
            sd = int'($signed(d));
            e.q = 8'(sn / sd); e.r = 8'(sn % sd); e.dbz = 1'b0;
        end
        return e;
    endfunction

    function automatic void check_out(input int i, input exp_t e);
        chk((i == 0) ? "q_unsigned" : "q_signed", 32'(q_o[i]), 32'(e.q));
        chk((i == 0) ? "r_unsigned" : "r_signed", 32'(r_o[i]), 32'(e.r));
        chk((i == 0) ? "dbz_unsigned" : "dbz_signed", 32'(dbz_o[i]), 32'(e.dbz));
    endfunction

    // Monitor: every negedge with out_valid & out_ready is exactly one transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (ov[0] && out_ready[0]) begin
                rx[0] = rx[0] + 1;
                if (sb0.size() == 0) chk("extra_result0", 32'd1, 32'd0);
                else check_out(0, sb0.pop_front());
            end
            if (ov[1] && out_ready[1]) begin
                rx[1] = rx[1] + 1;
                if (sb1.size() == 0) chk("extra_result1", 32'd1, 32'd0);
                else check_out(1, sb1.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic issue(input int i, input logic [7:0] n, input logic [7:0] d, input bit push);
        int t;
        bit ok;
        t = 0;
        ok = 1'b0;
        in_valid[i] = 1'b1;
        n_in[i] = n;
        d_in[i] = d;
        while (!ok && t < 300) begin
            @(negedge clk);
            ok = ir[i];
            @(posedge clk);
            #1;
            t = t + 1;
        end
        in_valid[i] = 1'b0;
        n_in[i] = 8'($urandom);
        d_in[i] = 8'($urandom);
        chk("accept_timeout", 32'(ok), 32'd1);
        if (ok && push) begin
            if (i == 0) sb0.push_back(model(i, n, d));
            else        sb1.push_back(model(i, n, d));
            tx[i] = tx[i] + 1;
        end
    endtask

    task automatic run_lat(input int i, input logic [7:0] n, input logic [7:0] d, input int lat);
        int cyc;
        issue(i, n, d, 1'b1);
        cyc = 0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (ov[i]) break;
            chk("in_ready_while_busy", 32'(ir[i]), 32'd0);
        end
        chk("latency", 32'(cyc), 32'(lat));
    endtask

    task automatic wait_idle(input int i);
        for (int t = 0; t < 100; t++) begin
            if (ir[i]) break;
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", 32'(ir[i]), 32'd1);
    endtask

    task automatic rand_ops(input int i, input int cnt);
        logic [7:0] n, d;
        for (int k = 0; k < cnt; k++) begin
            n = 8'($urandom);
            d = 8'($urandom);
            case ($urandom_range(0, 9))
                0: d = 8'd1;
                1: n = 8'd0;
                2: d = n;
                3: n = (i == 0) ? 8'hFF : 8'h7F;
                4: d = (i == 0) ? 8'hFF : 8'h80;
                5: d = 8'd0;
                6: begin n = 8'h80; d = 8'hFF; end
                default: ;
            endcase
            issue(i, n, d, 1'b1);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b1;
            n_in[i] = 8'd0; d_in[i] = 8'd0; tx[i] = 0; rx[i] = 0;
        end
        rand_done = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", 32'(ir[i]), 32'd1);
            chk("rst_out_valid", 32'(ov[i]), 32'd0);
            chk("rst_busy", 32'(busy_o[i]), 32'd0);
            chk("rst_q", 32'(q_o[i]), 32'd0);
            chk("rst_r", 32'(r_o[i]), 32'd0);
            chk("rst_dbz", 32'(dbz_o[i]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unsigned basic case and full-length latency
        run_lat(0, 8'd200, 8'd7, 9);
        wait_idle(0);

        // Signed sign handling
        issue(1, 8'hF9, 8'h02, 1'b1);
        wait_idle(1);
        issue(1, 8'h07, 8'hFE, 1'b1);
        wait_idle(1);

        // Divide-by-zero and signed overflow take a single cycle
        run_lat(0, 8'h55, 8'h00, 1);
        wait_idle(0);
        run_lat(1, 8'h80, 8'hFF, 1);
        wait_idle(1);

        // Back-pressure with an ignored in_valid pulse while busy
        out_ready[0] = 1'b0;
        run_lat(0, 8'd45, 8'd6, 9);
        for (int k = 0; k < 5; k++) begin
            chk("bp_out_valid", 32'(ov[0]), 32'd1);
            chk("bp_in_ready", 32'(ir[0]), 32'd0);
            chk("bp_q", 32'(q_o[0]), 32'd7);
            chk("bp_r", 32'(r_o[0]), 32'd3);
            in_valid[0] = (k == 1);
            n_in[0] = 8'd9;
            d_in[0] = 8'd3;
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 32'(ov[0]), 32'd0);
        chk("bp_release_in_ready", 32'(ir[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("bp_pulse_ignored_busy", 32'(busy_o[0]), 32'd0);

        // Asynchronous reset in the middle of CALC
        issue(0, 8'd50, 8'd3, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 32'(ov[0]), 32'd0);
        chk("abort_in_ready", 32'(ir[0]), 32'd1);
        chk("abort_busy", 32'(busy_o[0]), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_lat(0, 8'd100, 8'd10, 9);
        wait_idle(0);

        // Random back-to-back traffic with random back-pressure
        fork
            begin
                fork
                    rand_ops(0, 550);
                    rand_ops(1, 550);
                join
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready[0] = ($urandom_range(0, 3) != 0);
                    out_ready[1] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (sb0.size() == 0 && sb1.size() == 0 && ir[0] && ir[1]) break;
            @(posedge clk);
            #1;
        end
        chk("drain_pending0", 32'(sb0.size()), 32'd0);
        chk("drain_pending1", 32'(sb1.size()), 32'd0);
        chk("count_unsigned", 32'(rx[0]), 32'(tx[0]));
        chk("count_signed", 32'(rx[1]), 32'(tx[1]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
